// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - word-addressed register bus between the system bridge and the timer
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - prescaled down-counting timer with one-shot / auto-reload interrupt
module timer_counter #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  timer_counter_if.slave   bus,
  output logic             irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [31:0]   preset_q, preset_d;
  logic [31:0]   count_q, count_d;
  logic          pending_q, pending_d;
  logic [PW-1:0] presc_q, presc_d;

  logic wr_ctrl, wr_preset, tick, enable, auto_reload;

  assign wr_ctrl     = bus.we && (bus.addr == 2'd0);
  assign wr_preset   = bus.we && (bus.addr == 2'd1);
  assign tick        = (presc_q == PRESC_MAX);
  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    presc_d   = presc_q;

    case (state_q)
      S_IDLE: if (enable) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        presc_d = '0;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          // PRESET of 0 behaves like 1: expire on the first tick
          if (tick) begin
            if (count_q <= 32'd1) begin
              count_d   = '0;
              pending_d = 1'b1;
              state_d   = S_INT;
            end else begin
              count_d = count_q - 32'd1;
            end
          end
        end
      end
      S_INT: begin
        if (auto_reload) begin
          pending_d = 1'b0;
          state_d   = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes are applied last so they win over FSM-side register updates
    if (wr_ctrl) begin
      ctrl_d    = bus.din[3:0];
      pending_d = 1'b0;
    end
    if (wr_preset) preset_d = bus.din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
    end
  end

  always_comb begin
    case (bus.addr)
      2'd0:    bus.dout = {28'd0, ctrl_q};
      2'd1:    bus.dout = preset_q;
      2'd2:    bus.dout = count_q;
      default: bus.dout = 32'd0;
    endcase
  end

  assign irq = ctrl_q[3] & pending_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - scoreboard bench for timer_counter (PRESCALE 1 and 4 instances)
module tb_timer_counter;

  localparam int K_IRQ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  int          sel = 0;

  logic irq0, irq1;
  logic [31:0] dout_obs;
  logic        irq_obs;

  timer_counter_if if0 ();
  timer_counter_if if1 ();

  assign if0.addr = addr;
  assign if0.din  = din;
  assign if0.we   = we && (sel == 0);
  assign if1.addr = addr;
  assign if1.din  = din;
  assign if1.we   = we && (sel == 1);
  assign dout_obs = (sel == 1) ? if1.dout : if0.dout;
  assign irq_obs  = (sel == 1) ? irq1 : irq0;

  timer_counter #(.PRESCALE(1)) u_dut0 (.clk(clk), .reset(reset), .bus(if0), .irq(irq0));
  timer_counter #(.PRESCALE(4)) u_dut1 (.clk(clk), .reset(reset), .bus(if1), .irq(irq1));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic want(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == K_IRQ) begin
        obs = {31'd0, irq_obs};
      end else begin
        addr = e.kind[1:0];
        #1;
        obs = dout_obs;
      end
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    drain();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    // reset state
    want("rst_ctrl", 0, 0);
    want("rst_preset", 1, 0);
    want("rst_count", 2, 0);
    want("rst_addr3", 3, 0);
    want("rst_irq", K_IRQ, 0);
    idle();
    reset = 1'b0;
    idle();

    // mode 0, unmasked
    want("m0_preset", 1, 5);
    wr(2'd1, 32'd5);
    want("m0_ctrl_wr", 0, 32'h9);
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 10; e++) begin
      if (e <= 7) want("m0_count", 2, (e < 2) ? 0 : 7 - e);
      want("m0_irq", K_IRQ, (e >= 7) ? 1 : 0);
      if (e >= 8) want("m0_ctrl_done", 0, 32'h8);
      idle();
    end
    want("m0_irq_clr", K_IRQ, 0);
    want("m0_ctrl_clr", 0, 0);
    wr(2'd0, 32'h0);

    // mode 0, masked
    wr(2'd0, 32'h1);
    for (int e = 1; e <= 10; e++) begin
      if (e <= 7) want("mask_count", 2, (e < 2) ? 0 : 7 - e);
      want("mask_irq", K_IRQ, 0);
      if (e >= 8) want("mask_ctrl", 0, 32'h0);
      idle();
    end

    // mode 1 auto-reload
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 17; e++) begin
      int p;
      p = (e - 2) % 5;
      want("m1_irq", K_IRQ, (e >= 5 && (e - 5) % 5 == 0) ? 1 : 0);
      if (e >= 2) want("m1_count", 2, (p == 0) ? 3 : (p == 1) ? 2 : (p == 2) ? 1 : 0);
      idle();
    end

    // asynchronous reset between edges while COUNT = 3
    #1;
    reset = 1'b1;
    #1;
    want("arst_count", 2, 0);
    want("arst_ctrl", 0, 0);
    want("arst_preset", 1, 0);
    want("arst_irq", K_IRQ, 0);
    drain();
    #1;
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      want("post_rst_count", 2, 0);
      want("post_rst_irq", K_IRQ, 0);
      idle();
    end
    wr(2'd1, 32'd2);
    for (int e = 0; e < 4; e++) begin
      want("post_rst_idle", 2, 0);
      idle();
    end

    // disable during CNT, then re-enable
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 4; e++) begin
      want("dis_count", 2, (e < 2) ? 0 : 12 - e);
      idle();
    end
    want("dis_wr_count", 2, 7);
    wr(2'd0, 32'h8);
    for (int e = 0; e < 3; e++) begin
      want("dis_frozen", 2, 7);
      want("dis_irq", K_IRQ, 0);
      idle();
    end
    want("reen_e0", 2, 7);
    wr(2'd0, 32'h9);
    want("reen_e1", 2, 7);
    idle();
    want("reen_e2", 2, 10);
    idle();
    want("reen_e3", 2, 9);
    idle();
    want("reen_off", 0, 0);
    wr(2'd0, 32'h0);
    idle();

    // PRESET 0 acts as 1, ignored writes
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle();
    want("p0_count", 2, 0);
    want("p0_irq_e2", K_IRQ, 0);
    idle();
    want("p0_irq_e3", K_IRQ, 1);
    idle();
    want("p0_ctrl", 0, 32'h8);
    idle();
    want("count_ro", 2, 0);
    wr(2'd2, 32'd123);
    want("addr3_ro", 3, 0);
    want("addr3_preset", 1, 0);
    wr(2'd3, 32'd55);
    want("ctrl_hi_bits", 0, 0);
    want("ctrl_wr_clr_irq", K_IRQ, 0);
    wr(2'd0, 32'hFFFF_FFF0);

    // PRESCALE = 4 instance
    sel = 1;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 12; e++) begin
      want("ps_count", 2, (e < 2) ? 0 : (e < 6) ? 2 : (e < 10) ? 1 : 0);
      want("ps_irq", K_IRQ, (e >= 10) ? 1 : 0);
      idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
